// File: rtl/rotenc_quad.sv
// ---------------------------------------------------------------------------
// rotenc_quad
//
// Quadrature rotary-encoder position counter. Each raw encoder channel is
// brought into the clk domain by a synchroniser chain. It is then debounced
// by a persistence filter. The filtered {A,B} pair drives a Gray-code
// transition decoder. Decoded steps move an up/down position counter in x1,
// x2 or x4 resolution. The counter wraps or saturates at its bounds.
// Transitions where both channels change at once cannot come from a real
// encoder, so they raise a sticky error flag.
//
// Parameters:
//   CNT_W        counter width in bits (>= 4)
//   SYNC_STAGES  synchroniser flops per channel (>= 2)
//   FILT_LEN     cycles a synced input must disagree with its filtered value
//                before the new value is accepted (>= 1)
//   CNT_INIT     counter value after reset or clr (mid-scale by default)
//   SATURATE     0 = wrap modulo 2**CNT_W, 1 = clamp at 0 and all-ones
//
// Ports:
//   clk      in   rising-edge clock
//   rst      in   asynchronous active-high reset
//   a, b     in   raw encoder channels, asynchronous to clk
//   mode     in   2'b00 = x1, 2'b01 = x2, 2'b1x = x4
//   en       in   count enable (decoding continues while low)
//   clr      in   synchronous clear of cnt to CNT_INIT
//   err_clr  in   clears the sticky err flag
//   cnt      out  position count
//   dir      out  direction of the last counted step, 1 = up
//   step     out  one-cycle pulse while cnt shows a freshly counted step
//   err      out  sticky illegal-transition flag
// ---------------------------------------------------------------------------
module rotenc_quad #(
    parameter int              CNT_W       = 16,
    parameter int              SYNC_STAGES = 2,
    parameter int              FILT_LEN    = 4,
    parameter logic [CNT_W-1:0] CNT_INIT   = {1'b1, {(CNT_W-1){1'b0}}},
    parameter bit              SATURATE    = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a,
    input  logic             b,
    input  logic [1:0]       mode,
    input  logic             en,
    input  logic             clr,
    input  logic             err_clr,
    output logic [CNT_W-1:0] cnt,
    output logic             dir,
    output logic             step,
    output logic             err
);

    // Encoder phases in {A,B} order, listed in the up-count sequence.
    // A leads B when the shaft turns in the up direction.
    localparam logic [1:0] PH0 = 2'b00;
    localparam logic [1:0] PH1 = 2'b10;
    localparam logic [1:0] PH2 = 2'b11;
    localparam logic [1:0] PH3 = 2'b01;

    localparam logic [1:0] MODE_X1 = 2'b00;
    localparam logic [1:0] MODE_X2 = 2'b01;

    // A FILT_LEN of 1 still needs a one-bit counter so the filter logic
    // keeps the same shape.
    localparam int               FC_W    = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;
    localparam logic [FC_W-1:0]  FC_LAST = FC_W'(FILT_LEN - 1);
    localparam logic [FC_W-1:0]  FC_ONE  = FC_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;

    logic [SYNC_STAGES-1:0] a_sync;
    logic [SYNC_STAGES-1:0] b_sync;
    logic                   a_synced;
    logic                   b_synced;

    logic                   a_filt;
    logic                   b_filt;
    logic [FC_W-1:0]        a_fc;
    logic [FC_W-1:0]        b_fc;

    logic [1:0]             cur_state;
    logic [1:0]             prev_state;

    logic                   up_valid;
    logic                   dn_valid;
    logic                   illegal;
    logic                   mode_sel;
    logic                   count_up;
    logic                   count_dn;

    // Synchroniser chains. The raw pins are shifted in at the low end, and
    // only the last stage is used downstream, so metastability in the first
    // flop has SYNC_STAGES-1 cycles to settle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_sync <= '0;
            b_sync <= '0;
        end else begin
            a_sync <= {a_sync[SYNC_STAGES-2:0], a};
            b_sync <= {b_sync[SYNC_STAGES-2:0], b};
        end
    end

    assign a_synced = a_sync[SYNC_STAGES-1];
    assign b_synced = b_sync[SYNC_STAGES-1];

    // Channel A persistence filter. The synced value must disagree with the
    // filtered value for FILT_LEN consecutive cycles before it is adopted.
    // Any agreement in between restarts the count, so a contact-bounce
    // glitch shorter than FILT_LEN cycles never reaches the decoder.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            a_filt <= 1'b0;
            a_fc   <= '0;
        end else if (a_synced == a_filt) begin
            a_fc   <= '0;
        end else if (a_fc == FC_LAST) begin
            a_filt <= a_synced;
            a_fc   <= '0;
        end else begin
            a_fc   <= a_fc + FC_ONE;
        end
    end

    // Channel B persistence filter, identical in behaviour to channel A.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            b_filt <= 1'b0;
            b_fc   <= '0;
        end else if (b_synced == b_filt) begin
            b_fc   <= '0;
        end else if (b_fc == FC_LAST) begin
            b_filt <= b_synced;
            b_fc   <= '0;
        end else begin
            b_fc   <= b_fc + FC_ONE;
        end
    end

    assign cur_state = {a_filt, b_filt};

    // Previous-phase register. It follows the filtered state every cycle,
    // even on illegal jumps, so that decoding re-locks straight away.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_state <= PH0;
        end else begin
            prev_state <= cur_state;
        end
    end

    // Transition decoder. Each valid move is one step along the Gray ring,
    // forward for up and backward for down. A move where both bits flip
    // skips a phase, so its direction is unknown and it is only flagged.
    always_comb begin
        up_valid = 1'b0;
        dn_valid = 1'b0;
        unique case ({prev_state, cur_state})
            {PH0, PH1}, {PH1, PH2}, {PH2, PH3}, {PH3, PH0}: up_valid = 1'b1;
            {PH0, PH3}, {PH3, PH2}, {PH2, PH1}, {PH1, PH0}: dn_valid = 1'b1;
            default: ;
        endcase
        illegal = ((prev_state ^ cur_state) == 2'b11);
    end

    // Resolution select. x1 counts only rising edges of B: 10->11 going up
    // and 00->01 going down. x2 counts every B edge, and x4 counts every
    // valid transition. A valid move that is not selected is simply
    // ignored. Mode is looked at only when a move happens, so changing it
    // never recounts past moves.
    always_comb begin
        mode_sel = 1'b1;
        if (mode == MODE_X1) begin
            mode_sel = ~prev_state[0] & cur_state[0];
        end else if (mode == MODE_X2) begin
            mode_sel = prev_state[0] ^ cur_state[0];
        end
        count_up = up_valid & mode_sel;
        count_dn = dn_valid & mode_sel;
    end

    // Position counter. clr has the highest priority and suppresses any
    // step in the same cycle. When en is low, a decoded step is dropped
    // completely, so step and dir stay unchanged. In saturating builds, a
    // step at the bound still pulses step and updates dir, so software can
    // see that the shaft is still moving even while the count is pinned.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt  <= CNT_INIT;
            dir  <= 1'b0;
            step <= 1'b0;
        end else begin
            step <= 1'b0;
            if (clr) begin
                cnt <= CNT_INIT;
            end else if (en && count_up) begin
                step <= 1'b1;
                dir  <= 1'b1;
                if (!(SATURATE && (cnt == CNT_MAX))) begin
                    cnt <= cnt + CNT_ONE;
                end
            end else if (en && count_dn) begin
                step <= 1'b1;
                dir  <= 1'b0;
                if (!(SATURATE && (cnt == CNT_MIN))) begin
                    cnt <= cnt - CNT_ONE;
                end
            end
        end
    end

    // Sticky error flag. A fresh illegal transition wins over err_clr, so
    // an error that coincides with the clear request is never lost.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if (illegal) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rotenc_quad.sv
// ---------------------------------------------------------------------------
// tb_rotenc_quad
//
// Self-checking bench for rotenc_quad. It drives three instances from one
// stimulus:
//   - the default 16-bit build;
//   - a 4-bit wrapping build with CNT_INIT = 15;
//   - a 4-bit saturating build with CNT_INIT = 15.
// Each encoder level that is applied runs through a small Gray-ring model.
// When the model predicts a counted step, the expected {cnt, dir} is queued.
// A negedge monitor pops one entry for every step pulse from the 16-bit
// instance and compares it with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_rotenc_quad;

    logic        clk = 1'b0;
    logic        rst;
    logic        a;
    logic        b;
    logic [1:0]  mode;
    logic        en;
    logic        clr;
    logic        err_clr;

    logic [15:0] cnt;
    logic        dir;
    logic        step;
    logic        err;

    logic [3:0]  w_cnt;
    logic        w_dir;
    logic        w_step;
    logic        w_err;

    logic [3:0]  s_cnt;
    logic        s_dir;
    logic        s_step;
    logic        s_err;

    typedef struct packed {
        logic [15:0] cnt;
        logic        dir;
    } exp_t;

    exp_t        exp_q[$];
    logic [1:0]  model_p;
    logic [15:0] model_cnt;
    logic        model_dir;
    logic        model_err;

    int          n_cmp      = 0;
    int          n_fail     = 0;
    int          steps_seen = 0;
    bit          mon_en     = 1'b0;

    always #5 clk = ~clk;

    rotenc_quad dut (
        .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .en(en), .clr(clr),
        .err_clr(err_clr), .cnt(cnt), .dir(dir), .step(step), .err(err)
    );

    rotenc_quad #(.CNT_W(4), .CNT_INIT(4'd15), .SATURATE(1'b0)) dut_wrap (
        .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .en(en), .clr(clr),
        .err_clr(err_clr), .cnt(w_cnt), .dir(w_dir), .step(w_step), .err(w_err)
    );

    rotenc_quad #(.CNT_W(4), .CNT_INIT(4'd15), .SATURATE(1'b1)) dut_sat (
        .clk(clk), .rst(rst), .a(a), .b(b), .mode(mode), .en(en), .clr(clr),
        .err_clr(err_clr), .cnt(s_cnt), .dir(s_dir), .step(s_step), .err(s_err)
    );

    // Step monitor. Every step pulse from the 16-bit instance must match
    // the oldest expectation in the queue. A pulse with nothing queued is
    // an unexpected count.
    always @(negedge clk) begin
        exp_t e;
        if (mon_en && !rst && step === 1'b1) begin
            steps_seen++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_fail++;
                $display("[TB] FAIL unexpected_step: got step with cnt=%h, expected no step", cnt);
            end else begin
                e = exp_q.pop_front();
                n_cmp++;
                if (cnt !== e.cnt) begin
                    n_fail++;
                    $display("[TB] FAIL step_cnt: got %h expected %h", cnt, e.cnt);
                end
                n_cmp++;
                if (dir !== e.dir) begin
                    n_fail++;
                    $display("[TB] FAIL step_dir: got %b expected %b", dir, e.dir);
                end
            end
        end
    end

    // Position of a phase along the up-count ring 00 -> 10 -> 11 -> 01.
    function automatic int ring_pos(input logic [1:0] v);
        case (v)
            2'b00:   return 0;
            2'b10:   return 1;
            2'b11:   return 2;
            default: return 3;
        endcase
    endfunction

    // Apply a new encoder level at a falling edge and update the model.
    // When no_count is set, the move is tracked but no step is queued.
    // That is used where clr is expected to swallow the step.
    task automatic set_level(input logic [1:0] s, input bit no_count);
        int   d;
        bit   sel;
        exp_t e;
        @(negedge clk);
        {a, b} = s;
        if (s != model_p) begin
            d = (ring_pos(s) - ring_pos(model_p) + 4) % 4;
            if (d == 2) begin
                model_err = 1'b1;
            end else begin
                if (mode[1])
                    sel = 1'b1;
                else if (mode == 2'b01)
                    sel = (s[0] != model_p[0]);
                else
                    sel = (s[0] && !model_p[0]);
                if (sel && en && !no_count) begin
                    if (d == 1) begin
                        model_cnt = model_cnt + 16'd1;
                        model_dir = 1'b1;
                    end else begin
                        model_cnt = model_cnt - 16'd1;
                        model_dir = 1'b0;
                    end
                    e.cnt = model_cnt;
                    e.dir = model_dir;
                    exp_q.push_back(e);
                end
            end
        end
        model_p = s;
    endtask

    task automatic hold(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst     = 1'b1;
        {a, b}  = 2'b00;
        en      = 1'b1;
        clr     = 1'b0;
        err_clr = 1'b0;
        mode    = 2'b10;
        repeat (2) @(negedge clk);
        rst        = 1'b0;
        model_p    = 2'b00;
        model_cnt  = 16'h8000;
        model_dir  = 1'b0;
        model_err  = 1'b0;
        steps_seen = 0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        @(posedge clk);
        #1;
        n_cmp++; if (cnt !== 16'h8000) begin n_fail++; $display("[TB] FAIL reset_cnt: got %h expected 8000", cnt); end
        n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_dir: got %b expected 0", dir); end
        n_cmp++; if (step !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_step: got %b expected 0", step); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_err: got %b expected 0", err); end
        n_cmp++; if (w_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL reset_cnt_w4: got %h expected f", w_cnt); end
    endtask

    // Four full encoder cycles in one direction, with each level held for
    // 10 cycles.
    task automatic test_cycles(input string name, input logic [1:0] m, input bit up,
                               input logic [15:0] exp_cnt, input logic exp_dir,
                               input int exp_steps);
        logic [1:0] seq [4];
        do_reset();
        mode = m;
        if (up) seq = '{2'b10, 2'b11, 2'b01, 2'b00};
        else    seq = '{2'b01, 2'b11, 2'b10, 2'b00};
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                set_level(seq[j], 1'b0);
                hold(10);
            end
        end
        hold(12);
        #1;
        n_cmp++; if (cnt !== exp_cnt) begin n_fail++; $display("[TB] FAIL %s cnt: got %h expected %h", name, cnt, exp_cnt); end
        n_cmp++; if (dir !== exp_dir) begin n_fail++; $display("[TB] FAIL %s dir: got %b expected %b", name, dir, exp_dir); end
        n_cmp++; if (steps_seen != exp_steps) begin n_fail++; $display("[TB] FAIL %s steps: got %0d expected %0d", name, steps_seen, exp_steps); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL %s err: got %b expected 0", name, err); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL %s pending: got %0d unmatched expectations expected 0", name, exp_q.size()); end
    endtask

    task automatic test_latency_glitch();
        do_reset();
        mode = 2'b10;
        set_level(2'b10, 1'b0);
        repeat (6) @(posedge clk);
        #1;
        n_cmp++; if (cnt !== 16'h8000) begin n_fail++; $display("[TB] FAIL latency_early: got %h expected 8000", cnt); end
        @(posedge clk);
        #1;
        n_cmp++; if (cnt !== 16'h8001) begin n_fail++; $display("[TB] FAIL latency_edge7: got %h expected 8001", cnt); end
        hold(5);
        // A 3-cycle pulse on B is one cycle too short to pass the filter.
        @(negedge clk);
        b = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        b = 1'b0;
        hold(15);
        #1;
        n_cmp++; if (cnt !== 16'h8001) begin n_fail++; $display("[TB] FAIL glitch_cnt: got %h expected 8001", cnt); end
        n_cmp++; if (steps_seen != 1) begin n_fail++; $display("[TB] FAIL glitch_steps: got %0d expected 1", steps_seen); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL glitch_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_err();
        do_reset();
        mode = 2'b10;
        set_level(2'b11, 1'b0);
        hold(10);
        #1;
        n_cmp++; if (err !== model_err) begin n_fail++; $display("[TB] FAIL err_set: got %b expected %b", err, model_err); end
        n_cmp++; if (cnt !== 16'h8000) begin n_fail++; $display("[TB] FAIL err_cnt: got %h expected 8000", cnt); end
        // The second illegal jump lands on the 7th edge. err_clr is held
        // high only around that edge.
        set_level(2'b00, 1'b0);
        repeat (6) @(posedge clk);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL err_set_wins: got %b expected 1", err); end
        hold(3);
        @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        #1;
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL err_clear: got %b expected 0", err); end
        n_cmp++; if (steps_seen != 0) begin n_fail++; $display("[TB] FAIL err_steps: got %0d expected 0", steps_seen); end
    endtask

    task automatic test_wrap_saturate();
        do_reset();
        mode = 2'b10;
        set_level(2'b10, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        n_cmp++; if (w_cnt !== 4'd0) begin n_fail++; $display("[TB] FAIL wrap_up_cnt: got %h expected 0", w_cnt); end
        n_cmp++; if (w_step !== 1'b1) begin n_fail++; $display("[TB] FAIL wrap_up_step: got %b expected 1", w_step); end
        n_cmp++; if (s_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL sat_up_cnt: got %h expected f", s_cnt); end
        n_cmp++; if (s_step !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_up_step: got %b expected 1", s_step); end
        n_cmp++; if (s_dir !== 1'b1) begin n_fail++; $display("[TB] FAIL sat_up_dir: got %b expected 1", s_dir); end
        hold(5);
        set_level(2'b00, 1'b0);
        repeat (7) @(posedge clk);
        #1;
        n_cmp++; if (w_cnt !== 4'd15) begin n_fail++; $display("[TB] FAIL wrap_down_cnt: got %h expected f", w_cnt); end
        n_cmp++; if (w_dir !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_down_dir: got %b expected 0", w_dir); end
        n_cmp++; if (s_cnt !== 4'd14) begin n_fail++; $display("[TB] FAIL sat_down_cnt: got %h expected e", s_cnt); end
        n_cmp++; if ((w_err | s_err) !== 1'b0) begin n_fail++; $display("[TB] FAIL w4_err: got %b expected 0", w_err | s_err); end
        hold(5);
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL wrap_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_clr_collision();
        do_reset();
        mode = 2'b10;
        set_level(2'b10, 1'b0);
        hold(10);
        set_level(2'b11, 1'b0);
        hold(10);
        // A down step arrives on the 7th edge, and clr must swallow it.
        mon_en = 1'b0;
        set_level(2'b10, 1'b1);
        repeat (6) @(posedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++; if (cnt !== 16'h8000) begin n_fail++; $display("[TB] FAIL clr_cnt: got %h expected 8000", cnt); end
        n_cmp++; if (step !== 1'b0) begin n_fail++; $display("[TB] FAIL clr_step: got %b expected 0", step); end
        n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("[TB] FAIL clr_dir: got %b expected 1", dir); end
        @(negedge clk);
        clr       = 1'b0;
        model_cnt = 16'h8000;
        hold(3);
        mon_en = 1'b1;
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL clr_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_enable();
        logic [1:0] seq [4];
        do_reset();
        mode = 2'b10;
        en   = 1'b0;
        seq  = '{2'b10, 2'b11, 2'b01, 2'b00};
        for (int j = 0; j < 4; j++) begin
            set_level(seq[j], 1'b0);
            hold(10);
        end
        #1;
        n_cmp++; if (cnt !== 16'h8000) begin n_fail++; $display("[TB] FAIL en_off_cnt: got %h expected 8000", cnt); end
        n_cmp++; if (steps_seen != 0) begin n_fail++; $display("[TB] FAIL en_off_steps: got %0d expected 0", steps_seen); end
        n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("[TB] FAIL en_off_dir: got %b expected 0", dir); end
        en = 1'b1;
        set_level(2'b10, 1'b0);
        hold(10);
        #1;
        n_cmp++; if (cnt !== 16'h8001) begin n_fail++; $display("[TB] FAIL en_on_cnt: got %h expected 8001", cnt); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL en_pending: got %0d expected 0", exp_q.size()); end
    endtask

    task automatic test_reset_mid();
        do_reset();
        mode = 2'b10;
        set_level(2'b10, 1'b0);
        hold(10);
        set_level(2'b11, 1'b0);
        hold(10);
        set_level(2'b00, 1'b0);
        hold(10);
        set_level(2'b10, 1'b0);
        repeat (3) @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        n_cmp++; if (cnt !== 16'h8000) begin n_fail++; $display("[TB] FAIL midrst_cnt: got %h expected 8000", cnt); end
        n_cmp++; if (dir !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_dir: got %b expected 0", dir); end
        n_cmp++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_err: got %b expected 0", err); end
        n_cmp++; if (step !== 1'b0) begin n_fail++; $display("[TB] FAIL midrst_step: got %b expected 0", step); end
        exp_q.delete();
        model_p   = 2'b00;
        model_cnt = 16'h8000;
        model_dir = 1'b0;
        model_err = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst        = 1'b0;
        steps_seen = 0;
        // A is still high, so the first move after reset is 00 -> 10 (up).
        set_level(2'b10, 1'b0);
        hold(12);
        #1;
        n_cmp++; if (cnt !== 16'h8001) begin n_fail++; $display("[TB] FAIL postrst_cnt: got %h expected 8001", cnt); end
        n_cmp++; if (dir !== 1'b1) begin n_fail++; $display("[TB] FAIL postrst_dir: got %b expected 1", dir); end
        n_cmp++; if (exp_q.size() != 0) begin n_fail++; $display("[TB] FAIL postrst_pending: got %0d expected 0", exp_q.size()); end
    endtask

    initial begin
        rst     = 1'b1;
        a       = 1'b0;
        b       = 1'b0;
        mode    = 2'b10;
        en      = 1'b1;
        clr     = 1'b0;
        err_clr = 1'b0;
        test_reset();
        mon_en = 1'b1;
        test_cycles("x4_up",   2'b10, 1'b1, 16'h8010, 1'b1, 16);
        test_cycles("x1_up",   2'b00, 1'b1, 16'h8004, 1'b1, 4);
        test_cycles("x2_up",   2'b01, 1'b1, 16'h8008, 1'b1, 8);
        test_cycles("x4_down", 2'b11, 1'b0, 16'h7FF0, 1'b0, 16);
        test_latency_glitch();
        test_err();
        test_wrap_saturate();
        test_clr_collision();
        test_enable();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/rotenc_quad.md
Name: rotenc_quad

Overview:
Parametrised quadrature rotary-encoder counter; successor to the single-edge 8-bit encoder counter.
- Synchronises and debounces the A/B inputs.
- Decodes in x1/x2/x4 resolution; counts up/down with wrap or saturate.
- Flags illegal Gray transitions.
- Sits between the raw encoder pins and the register/readout logic.

Parameters:
CNT_W, 16, counter width in bits (≥4)
SYNC_STAGES, 2, synchroniser flops per input (≥2)
FILT_LEN, 4, cycles a synced input must differ from its filtered value before it is accepted (≥1)
CNT_INIT, 2**(CNT_W-1), counter value after reset/clear (mid-scale)
SATURATE, 0, 0 = wrap at bounds, 1 = clamp at 0 / 2**CNT_W-1

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
a  in  1  encoder channel A, asynchronous
b  in  1  encoder channel B, asynchronous
mode  in  2  00 = x1, 01 = x2, 10/11 = x4; sampled every cycle
en  in  1  count enable; decoding/state tracking continue when low
clr  in  1  synchronous clear of cnt to CNT_INIT
err_clr  in  1  clears sticky err
cnt  out  CNT_W  position count
dir  out  1  direction of last counted step, 1 = up
step  out  1  one-cycle pulse, high in the cycle cnt takes a counted step
err  out  1  sticky illegal-transition flag

Behaviour:
- Interface: one clock, clk; reset is asynchronous and active-high, rst.
- Reset values:
  - all sync flops, filtered A/B and previous-state regs = 0
  - cnt = CNT_INIT; dir = 0; step = 0; err = 0
- Synchroniser: SYNC_STAGES-flop chain per channel.
- Filter, per channel, counter fc:
  - synced == filtered: fc <= 0.
  - Otherwise, if fc == FILT_LEN-1: filtered <= synced, fc <= 0; else fc <= fc+1.
  - Glitches shorter than FILT_LEN cycles never reach the decoder.
- Decoder: compares the filtered state s = {af,bf} with the registered previous state p; p <= s every cycle.
  - Up sequence: 00→10→11→01→00 (A leads B). Down sequence is the reverse.
  - x1: up on 10→11; down on 00→01 (B rising only).
  - x2: up on 10→11 and 01→00; down on 00→01 and 11→10 (all B edges).
  - x4: all four valid transitions in each direction.
  - Valid transition not selected by mode: no count, no err.
  - Both bits changing (00↔11, 01↔10): illegal. err <= 1; no count; p still updates.
- Latency: an input change reaches cnt after SYNC_STAGES+FILT_LEN+1 rising clk edges.
- Counter update priority: clr > counted step (only if en=1) > hold.
  - clr: cnt <= CNT_INIT; step = 0; dir unchanged.
  - Step with en=1:
    - cnt ± 1; step = 1; dir = 1 for up, 0 for down.
    - SATURATE=0: wraps modulo 2**CNT_W.
    - SATURATE=1: up at all-ones and down at 0 leave cnt unchanged; step still pulses, dir still updates.
  - Step with en=0: ignored entirely (no step, no dir change).
- err: set by an illegal transition, cleared by err_clr. Set in the same cycle as err_clr → err = 1.
- Mode change: takes effect on the next transition; no retroactive counting.
- rst mid-operation: all state returns to reset values immediately. First transition after release is judged against p = 00.

Test Plan:
- Reset then 4 full up cycles (00→10→11→01→00), each level held 10 cycles, mode=x4 → cnt = 0x8010, dir = 1, 16 step pulses, err = 0.
- Same stimulus, mode=x1 → cnt = 0x8004. Mode=x2 → cnt = 0x8008. Reverse sequence, x4 → cnt = 0x7FF0, dir = 0.
- Single A toggle 00→10 → cnt changes exactly SYNC_STAGES+FILT_LEN+1 = 7 edges later. A glitch held 3 cycles (FILT_LEN=4) → no step, no change.
- Jump 00→11 → err = 1, cnt unchanged. err_clr asserted the same cycle as a second illegal jump → err stays 1. err_clr alone → err = 0.
- CNT_W=4, CNT_INIT=15, SATURATE=0, one x4 up step → cnt = 0. Same with SATURATE=1 → cnt = 15, step = 1.
- clr asserted the same cycle as a step → cnt = CNT_INIT, step = 0. en=0 during 4 steps → cnt unchanged. rst pulse mid-sequence → all outputs at reset values asynchronously.
